row_transpose_buffer: RTL and testbench



---
 rtl/row_transpose_buffer.sv | 111 +++++++++++
 tb/tb_row_transpose_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/row_transpose_buffer.sv
// row_transpose_buffer
// Takes one stencil column per cycle and re-packs the columns into row-major
// words of FETCH_WIDTH pixels for the SRAM write port. Two banks let a new
// bank fill while the previous one drains.
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   col_pixels/valid    : column input, element r lands in row r
//   col_ready           : current write bank is not full
//   row_data/valid      : row word of the drain bank, element c is column c
//   row_ready           : downstream accepts the presented row
//   row_index, row_last : row being presented, last row of its bank
//   wr_buf, rd_buf      : bank being filled / drained
module row_transpose_buffer #(
    parameter int WORD_WIDTH     = 16,
    parameter int FETCH_WIDTH    = 4,
    parameter int STENCIL_HEIGHT = 3
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [STENCIL_HEIGHT-1:0][WORD_WIDTH-1:0]  col_pixels,
    input  logic                                       col_valid,
    output logic                                       col_ready,
    output logic [FETCH_WIDTH-1:0][WORD_WIDTH-1:0]     row_data,
    output logic                                       row_valid,
    input  logic                                       row_ready,
    output logic [$clog2(STENCIL_HEIGHT)-1:0]          row_index,
    output logic                                       row_last,
    output logic                                       wr_buf,
    output logic                                       rd_buf
);

    localparam int CW = $clog2(FETCH_WIDTH);
    localparam int RW = $clog2(STENCIL_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(FETCH_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(STENCIL_HEIGHT - 1);

    logic [CW-1:0] col_cnt;
    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          col_acc;
    logic          col_done;
    logic          row_acc;
    logic          row_done;

    // Data storage, intentionally not reset.
    logic [WORD_WIDTH-1:0] bank [2][STENCIL_HEIGHT][FETCH_WIDTH];

    assign col_ready = ~full[wr_buf];
    assign row_valid = full[rd_buf];
    assign row_last  = row_valid & (row_index == ROW_LAST);

    assign col_acc  = col_valid & col_ready;
    assign col_done = col_acc & (col_cnt == COL_LAST);
    assign row_acc  = row_valid & row_ready;
    assign row_done = row_acc & (row_index == ROW_LAST);

    // Set and clear always hit different banks (write bank is never full,
    // read bank always is), so applying both is safe.
    always_comb begin
        full_nxt = full;
        if (col_done) full_nxt[wr_buf] = 1'b1;
        if (row_done) full_nxt[rd_buf] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt   <= '0;
            wr_buf    <= 1'b0;
            rd_buf    <= 1'b0;
            row_index <= '0;
            full      <= 2'b00;
        end else begin
            full <= full_nxt;
            if (col_acc) begin
                if (col_done) begin
                    col_cnt <= '0;
                    wr_buf  <= ~wr_buf;
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
            end
            if (row_acc) begin
                if (row_done) begin
                    row_index <= '0;
                    rd_buf    <= ~rd_buf;
                end else begin
                    row_index <= row_index + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (col_acc) begin
            for (int r = 0; r < STENCIL_HEIGHT; r++) begin
                bank[wr_buf][r][col_cnt] <= col_pixels[r];
            end
        end
    end

    always_comb begin
        row_data = '0;
        if (row_valid) begin
            for (int c = 0; c < FETCH_WIDTH; c++) begin
                row_data[c] = bank[rd_buf][row_index][c];
            end
        end
    end

endmodule

// File: tb/tb_row_transpose_buffer.sv
module tb_row_transpose_buffer;

    localparam int W = 16;
    localparam int F = 4;
    localparam int H = 3;
    localparam int RW = $clog2(H);

    typedef logic [H-1:0][W-1:0] col_t;
    typedef logic [F-1:0][W-1:0] row_t;

    logic          clk = 1'b0;
    logic          rst_n;
    col_t          col_pixels;
    logic          col_valid;
    logic          col_ready;
    row_t          row_data;
    logic          row_valid;
    logic          row_ready;
    logic [RW-1:0] row_index;
    logic          row_last;
    logic          wr_buf;
    logic          rd_buf;

    int n_cmp = 0;
    int n_bad = 0;

    row_transpose_buffer #(
        .WORD_WIDTH(W), .FETCH_WIDTH(F), .STENCIL_HEIGHT(H)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .col_pixels(col_pixels), .col_valid(col_valid), .col_ready(col_ready),
        .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
        .row_index(row_index), .row_last(row_last),
        .wr_buf(wr_buf), .rd_buf(rd_buf)
    );

    always #5 clk = ~clk;

    // Reference model: pending columns of the bank being filled, and the
    // queue of complete rows not yet drained, in drain order.
    col_t cols_q[$];
    row_t rows_q[$];
    int   banks_done;
    int   rows_drained;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_valid();
        return rows_q.size() > 0;
    endfunction

    function automatic bit m_cready();
        return rows_q.size() <= H;
    endfunction

    function automatic int m_idx();
        return (rows_q.size() % H == 0) ? 0 : H - (rows_q.size() % H);
    endfunction

    function automatic row_t m_data();
        row_t d = '0;
        if (rows_q.size() > 0) d = rows_q[0];
        return d;
    endfunction

    task automatic model_clear();
        cols_q.delete();
        rows_q.delete();
        banks_done   = 0;
        rows_drained = 0;
    endtask

    task automatic model_push(input col_t c);
        row_t rw;
        cols_q.push_back(c);
        if (cols_q.size() == F) begin
            for (int r = 0; r < H; r++) begin
                for (int k = 0; k < F; k++) rw[k] = cols_q[k][r];
                rows_q.push_back(rw);
            end
            cols_q.delete();
            banks_done++;
        end
    endtask

    task automatic check_outputs();
        check_val("row_valid", row_valid, m_valid());
        check_val("col_ready", col_ready, m_cready());
        check_val("row_data",  row_data,  m_data());
        check_val("row_index", row_index, m_valid() ? m_idx() : 0);
        check_val("row_last",  row_last,  m_valid() && m_idx() == H - 1);
        check_val("wr_buf",    wr_buf,    banks_done % 2);
        check_val("rd_buf",    rd_buf,    (rows_drained / H) % 2);
    endtask

    // One clock cycle: drive, check current outputs, clock, update model.
    task automatic cycle(input logic cv, input col_t px, input logic rr, output bit took_col);
        bit acc_col, acc_row;
        col_valid  = cv;
        col_pixels = px;
        row_ready  = rr;
        #1;
        check_outputs();
        acc_col = cv && m_cready();
        acc_row = rr && m_valid();
        @(posedge clk);
        if (acc_row) begin
            void'(rows_q.pop_front());
            rows_drained++;
        end
        if (acc_col) model_push(px);
        took_col = acc_col;
        #1;
    endtask

    function automatic col_t mk_col(input int c);
        col_t p;
        for (int r = 0; r < H; r++) p[r] = W'(16 * r + c);
        return p;
    endfunction

    function automatic col_t rnd_col();
        col_t p;
        for (int r = 0; r < H; r++) p[r] = W'($urandom);
        return p;
    endfunction

    task automatic drain();
        bit t;
        for (int i = 0; i < 20 && rows_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, t);
        cycle(1'b0, '0, 1'b1, t);
    endtask

    initial begin
        bit   t;
        int   accepted;
        int   cyc;
        rst_n      = 1'b0;
        col_valid  = 1'b0;
        row_ready  = 1'b0;
        col_pixels = '0;
        model_clear();
        #12;
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic transpose: 4 columns, rows drain immediately.
        for (int c = 0; c < F; c++) cycle(1'b1, mk_col(c), 1'b1, t);
        check_val("first_rv", row_valid, 1'b1);
        check_val("first_row0", row_data, {16'd3, 16'd2, 16'd1, 16'd0});
        drain();

        // Streaming: 12 back-to-back columns.
        for (int c = 0; c < 12; c++) cycle(1'b1, mk_col(100 + c), 1'b1, t);
        drain();

        // Backpressure: 9 column attempts with row_ready low.
        for (int c = 0; c < 9; c++) cycle(1'b1, mk_col(200 + c), 1'b0, t);
        check_val("bp_col_ready", col_ready, 1'b0);
        for (int c = 0; c < 3; c++) cycle(1'b0, '0, 1'b1, t);
        check_val("bp_restored", col_ready, 1'b1);
        drain();

        // Last column of bank 1 lands with the last row of bank 0.
        for (int c = 0; c < 7; c++) cycle(1'b1, mk_col(300 + c), 1'b0, t);
        cycle(1'b0, '0, 1'b1, t);
        cycle(1'b0, '0, 1'b1, t);
        cycle(1'b1, mk_col(307), 1'b1, t);
        check_val("simul_rv", row_valid, 1'b1);
        check_val("simul_rd", rd_buf, 1'b1);
        drain();

        // Random stalls on both sides.
        accepted = 0;
        cyc = 0;
        while (accepted < 200 && cyc < 4000) begin
            cycle(1'($urandom % 2), rnd_col(), 1'($urandom % 2), t);
            if (t) accepted++;
            cyc++;
        end
        check_val("rand_cols", accepted, 200);
        drain();

        // Reset with one full bank and a partial one pending.
        for (int c = 0; c < 6; c++) cycle(1'b1, mk_col(400 + c), 1'b0, t);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_val("rst_rv_async", row_valid, 1'b0);
        check_outputs();
        @(posedge clk); #1;
        check_outputs();
        rst_n = 1'b1;
        for (int c = 0; c < F; c++) cycle(1'b1, mk_col(500 + c), 1'b1, t);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
